// File: rtl/game_sequencer_if.sv
// game_sequencer_if: tick, button, sub-unit handshake and status
// signals between the game sequencer and the rest of the game.
interface game_sequencer_if;
  logic       i_tick;
  logic       o_tick_done;
  logic       i_vblank;
  logic       i_up;
  logic       i_down;
  logic       i_left;
  logic       i_right;
  logic       i_restart;
  logic [1:0] o_dir;
  logic       o_move_start;
  logic       i_move_done;
  logic       i_collision;
  logic       i_ate;
  logic       o_grow_start;
  logic       i_grow_done;
  logic       o_food_start;
  logic       i_food_done;
  logic       o_clear_start;
  logic       i_clear_done;
  logic       o_mem_grant;
  logic       o_game_over;
  logic       o_overrun;
  logic       o_fault;

  modport master (
    input  i_tick, i_vblank,
    input  i_up, i_down, i_left, i_right,
    input  i_restart,
    input  i_move_done, i_collision, i_ate,
    input  i_grow_done, i_food_done,
    input  i_clear_done,
    output o_tick_done, o_dir,
    output o_move_start, o_grow_start,
    output o_food_start, o_clear_start,
    output o_mem_grant, o_game_over,
    output o_overrun, o_fault
  );

  modport slave (
    output i_tick, i_vblank,
    output i_up, i_down, i_left, i_right,
    output i_restart,
    output i_move_done, i_collision, i_ate,
    output i_grow_done, i_food_done,
    output i_clear_done,
    input  o_tick_done, o_dir,
    input  o_move_start, o_grow_start,
    input  o_food_start, o_clear_start,
    input  o_mem_grant, o_game_over,
    input  o_overrun, o_fault
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: per-tick snake update controller (clear, move,
// grow, food phases), direction latch, restart and game-over.
module game_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input logic              clk,
  input logic              rst_n,
  game_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    CLEAR_REQ,
    CLEAR_WAIT,
    IDLE,
    MOVE_WAIT,
    GROW_WAIT,
    FOOD_WAIT,
    DONE,
    GAME_OVER
  } state_t;

  state_t          state;
  logic [1:0]      pend;
  logic [TO_W-1:0] to_cnt;
  logic            restart_q;

  logic       any_dir;
  logic [1:0] cand;
  logic       restart_ok;
  logic       start_move;
  logic [1:0] ref_dir;
  logic       accept;
  logic       to_hit;
  logic       in_wait;

  assign any_dir = bus.i_up | bus.i_down |
                   bus.i_left | bus.i_right;

  always_comb begin
    cand = 2'd0;
    priority case (1'b1)
      bus.i_up:    cand = 2'd3;
      bus.i_down:  cand = 2'd1;
      bus.i_left:  cand = 2'd2;
      default:     cand = 2'd0;
    endcase
  end

  // Restart with a direction held is a config gesture, not a restart.
  assign restart_ok = bus.i_restart & ~restart_q & ~any_dir;

  assign start_move = (state == IDLE) & ~restart_ok &
                      bus.i_tick & bus.i_vblank;

  // On the commit cycle, judge reversal against the direction
  // being committed so a reversal cannot sneak into pending.
  assign ref_dir = start_move ? pend : bus.o_dir;
  assign accept  = any_dir & (cand != (ref_dir ^ 2'd2));

  assign to_hit  = to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign in_wait = (state == CLEAR_WAIT) | (state == MOVE_WAIT) |
                   (state == GROW_WAIT)  | (state == FOOD_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= CLEAR_REQ;
      pend              <= 2'd0;
      to_cnt            <= '0;
      restart_q         <= 1'b0;
      bus.o_dir         <= 2'd0;
      bus.o_tick_done   <= 1'b0;
      bus.o_move_start  <= 1'b0;
      bus.o_grow_start  <= 1'b0;
      bus.o_food_start  <= 1'b0;
      bus.o_clear_start <= 1'b0;
      bus.o_mem_grant   <= 1'b0;
      bus.o_game_over   <= 1'b0;
      bus.o_overrun     <= 1'b0;
      bus.o_fault       <= 1'b0;
    end else begin
      bus.o_move_start  <= 1'b0;
      bus.o_grow_start  <= 1'b0;
      bus.o_food_start  <= 1'b0;
      bus.o_clear_start <= 1'b0;
      restart_q         <= bus.i_restart;

      if (accept)
        pend <= cand;
      if (bus.o_mem_grant && !bus.i_vblank)
        bus.o_overrun <= 1'b1;
      if (in_wait)
        to_cnt <= to_cnt + 1'b1;

      unique case (state)
        CLEAR_REQ: begin
          bus.o_clear_start <= 1'b1;
          bus.o_mem_grant   <= 1'b1;
          to_cnt            <= '0;
          state             <= CLEAR_WAIT;
        end
        CLEAR_WAIT: begin
          if (bus.i_clear_done) begin
            bus.o_mem_grant <= 1'b0;
            bus.o_dir       <= 2'd0;
            pend            <= 2'd0;
            bus.o_fault     <= 1'b0;
            bus.o_overrun   <= 1'b0;
            state           <= IDLE;
          end else if (to_hit) begin
            bus.o_mem_grant <= 1'b0;
            bus.o_fault     <= 1'b1;
            state           <= IDLE;
          end
        end
        IDLE: begin
          if (restart_ok) begin
            state <= CLEAR_REQ;
          end else if (start_move) begin
            bus.o_dir        <= pend;
            bus.o_move_start <= 1'b1;
            bus.o_mem_grant  <= 1'b1;
            to_cnt           <= '0;
            state            <= MOVE_WAIT;
          end
        end
        MOVE_WAIT: begin
          if (bus.i_move_done) begin
            if (bus.i_collision) begin
              bus.o_mem_grant <= 1'b0;
              bus.o_game_over <= 1'b1;
              state           <= GAME_OVER;
            end else if (bus.i_ate) begin
              bus.o_grow_start <= 1'b1;
              to_cnt           <= '0;
              state            <= GROW_WAIT;
            end else begin
              bus.o_mem_grant <= 1'b0;
              bus.o_tick_done <= 1'b1;
              state           <= DONE;
            end
          end else if (to_hit) begin
            bus.o_mem_grant <= 1'b0;
            bus.o_fault     <= 1'b1;
            bus.o_game_over <= 1'b1;
            state           <= GAME_OVER;
          end
        end
        GROW_WAIT: begin
          if (bus.i_grow_done) begin
            bus.o_food_start <= 1'b1;
            to_cnt           <= '0;
            state            <= FOOD_WAIT;
          end else if (to_hit) begin
            bus.o_mem_grant <= 1'b0;
            bus.o_fault     <= 1'b1;
            bus.o_game_over <= 1'b1;
            state           <= GAME_OVER;
          end
        end
        FOOD_WAIT: begin
          if (bus.i_food_done) begin
            bus.o_mem_grant <= 1'b0;
            bus.o_tick_done <= 1'b1;
            state           <= DONE;
          end else if (to_hit) begin
            bus.o_mem_grant <= 1'b0;
            bus.o_fault     <= 1'b1;
            bus.o_game_over <= 1'b1;
            state           <= GAME_OVER;
          end
        end
        DONE: begin
          if (!bus.i_tick) begin
            bus.o_tick_done <= 1'b0;
            state           <= IDLE;
          end
        end
        GAME_OVER: begin
          // Ticks are acked without action so the generator never stalls.
          bus.o_tick_done <= bus.i_tick;
          if (restart_ok) begin
            bus.o_tick_done <= 1'b0;
            bus.o_game_over <= 1'b0;
            state           <= CLEAR_REQ;
          end
        end
        default: state <= CLEAR_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenario tests for game_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_game_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  game_sequencer_if bus();

  game_sequencer #(
    .TIMEOUT_CYCLES(255),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  // One plain tick: start, immediate move_done (no eat), release.
  task automatic run_tick();
    bus.i_tick = 1'b1;
    bus.i_vblank = 1'b1;
    cyc();
    bus.i_move_done = 1'b1;
    cyc();
    bus.i_move_done = 1'b0;
    bus.i_tick = 1'b0;
    cyc();
  endtask

  // Clear phase with i_clear_done given in the third grant cycle.
  task automatic run_clear(input string tag);
    int g;
    g = 0;
    for (int i = 0; i < 20 && !bus.o_clear_start; i++) cyc();
    checks++;
    if (bus.o_clear_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_clear_start got=%b exp=1", tag, bus.o_clear_start);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.o_mem_grant) g++;
      if (i == 2) bus.i_clear_done = 1'b1;
      else cyc();
    end
    cyc();
    bus.i_clear_done = 1'b0;
    checks++;
    if (g !== 3 || bus.o_mem_grant !== 1'b0) begin
      errors++;
      $display("FAIL %s_grant cycles=%0d now=%b exp=3,0", tag, g, bus.o_mem_grant);
    end
    checks++;
    if (bus.o_dir !== 2'd0) begin
      errors++;
      $display("FAIL %s_dir got=%0d exp=0", tag, bus.o_dir);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({bus.o_tick_done, bus.o_move_start, bus.o_grow_start,
         bus.o_food_start, bus.o_clear_start, bus.o_mem_grant,
         bus.o_game_over, bus.o_overrun, bus.o_fault,
         bus.o_dir} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {bus.o_tick_done,
        bus.o_move_start, bus.o_grow_start, bus.o_food_start,
        bus.o_clear_start, bus.o_mem_grant, bus.o_game_over,
        bus.o_overrun, bus.o_fault, bus.o_dir});
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (bus.o_clear_start !== 1'b1 || bus.o_mem_grant !== 1'b1) begin
      errors++;
      $display("FAIL clear_pulse_cycle1 start=%b grant=%b exp=1,1",
               bus.o_clear_start, bus.o_mem_grant);
    end
    run_clear("reset");
  endtask

  task automatic test_vblank_gate();
    int n;
    n = 0;
    bus.i_tick = 1'b1;
    bus.i_vblank = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.o_move_start) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL vblank_gate starts=%0d exp=0", n);
    end
    bus.i_vblank = 1'b1;
    cyc();
    checks++;
    if (bus.o_move_start !== 1'b1 || bus.o_mem_grant !== 1'b1) begin
      errors++;
      $display("FAIL move_start start=%b grant=%b exp=1,1",
               bus.o_move_start, bus.o_mem_grant);
    end
    bus.i_move_done = 1'b1;
    cyc();
    bus.i_move_done = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_move_start) n++;
      if (!bus.o_tick_done) n += 10;
      cyc();
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL done_hold code=%0d exp=0", n);
    end
    bus.i_tick = 1'b0;
    cyc();
    checks++;
    if (bus.o_tick_done !== 1'b0) begin
      errors++;
      $display("FAIL tick_done_release got=%b exp=0", bus.o_tick_done);
    end
    bus.i_tick = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.o_move_start) n++;
      if (i == 0) bus.i_move_done = 1'b1;
      else bus.i_move_done = 1'b0;
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL one_seq_per_tick starts=%0d exp=1", n);
    end
    bus.i_tick = 1'b0;
    cyc();
    cyc();
    checks++;
    if (bus.o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL no_overrun got=%b exp=0", bus.o_overrun);
    end
  endtask

  task automatic test_grow();
    bus.i_tick = 1'b1;
    bus.i_vblank = 1'b1;
    cyc();
    bus.i_move_done = 1'b1;
    bus.i_ate = 1'b1;
    cyc();
    bus.i_move_done = 1'b0;
    bus.i_ate = 1'b0;
    checks++;
    if ({bus.o_grow_start, bus.o_food_start, bus.o_mem_grant} !== 3'b101) begin
      errors++;
      $display("FAIL grow_pulse got=%b exp=101",
               {bus.o_grow_start, bus.o_food_start, bus.o_mem_grant});
    end
    cyc();
    checks++;
    if (bus.o_grow_start !== 1'b0) begin
      errors++;
      $display("FAIL grow_one_cycle got=%b exp=0", bus.o_grow_start);
    end
    bus.i_grow_done = 1'b1;
    cyc();
    bus.i_grow_done = 1'b0;
    checks++;
    if ({bus.o_grow_start, bus.o_food_start, bus.o_tick_done} !== 3'b010) begin
      errors++;
      $display("FAIL food_pulse got=%b exp=010",
               {bus.o_grow_start, bus.o_food_start, bus.o_tick_done});
    end
    cyc();
    checks++;
    if (bus.o_food_start !== 1'b0) begin
      errors++;
      $display("FAIL food_one_cycle got=%b exp=0", bus.o_food_start);
    end
    bus.i_food_done = 1'b1;
    cyc();
    bus.i_food_done = 1'b0;
    checks++;
    if (bus.o_tick_done !== 1'b1 || bus.o_mem_grant !== 1'b0) begin
      errors++;
      $display("FAIL grow_done done=%b grant=%b exp=1,0",
               bus.o_tick_done, bus.o_mem_grant);
    end
    bus.i_tick = 1'b0;
    cyc();
  endtask

  task automatic test_direction();
    bus.i_left = 1'b1;
    cyc();
    bus.i_left = 1'b0;
    run_tick();
    checks++;
    if (bus.o_dir !== 2'd0) begin
      errors++;
      $display("FAIL dir_reverse_left got=%0d exp=0", bus.o_dir);
    end
    bus.i_up = 1'b1;
    cyc();
    bus.i_up = 1'b0;
    cyc();
    checks++;
    if (bus.o_dir !== 2'd0) begin
      errors++;
      $display("FAIL dir_held_until_tick got=%0d exp=0", bus.o_dir);
    end
    run_tick();
    checks++;
    if (bus.o_dir !== 2'd3) begin
      errors++;
      $display("FAIL dir_up got=%0d exp=3", bus.o_dir);
    end
    bus.i_down = 1'b1;
    cyc();
    bus.i_down = 1'b0;
    run_tick();
    checks++;
    if (bus.o_dir !== 2'd3) begin
      errors++;
      $display("FAIL dir_reverse_down got=%0d exp=3", bus.o_dir);
    end
    bus.i_left = 1'b1;
    cyc();
    bus.i_left = 1'b0;
    bus.i_right = 1'b1;
    cyc();
    bus.i_right = 1'b0;
    run_tick();
    checks++;
    if (bus.o_dir !== 2'd0) begin
      errors++;
      $display("FAIL dir_last_wins got=%0d exp=0", bus.o_dir);
    end
    bus.i_up = 1'b1;
    bus.i_right = 1'b1;
    cyc();
    bus.i_up = 1'b0;
    bus.i_right = 1'b0;
    run_tick();
    checks++;
    if (bus.o_dir !== 2'd3) begin
      errors++;
      $display("FAIL dir_priority got=%0d exp=3", bus.o_dir);
    end
  endtask

  task automatic test_collision_restart();
    bus.i_tick = 1'b1;
    bus.i_vblank = 1'b1;
    cyc();
    bus.i_move_done = 1'b1;
    bus.i_collision = 1'b1;
    bus.i_ate = 1'b1;
    cyc();
    bus.i_move_done = 1'b0;
    bus.i_collision = 1'b0;
    bus.i_ate = 1'b0;
    checks++;
    if ({bus.o_game_over, bus.o_grow_start, bus.o_mem_grant} !== 3'b100) begin
      errors++;
      $display("FAIL collision got=%b exp=100",
               {bus.o_game_over, bus.o_grow_start, bus.o_mem_grant});
    end
    cyc();
    checks++;
    if (bus.o_tick_done !== 1'b1) begin
      errors++;
      $display("FAIL go_ack got=%b exp=1", bus.o_tick_done);
    end
    bus.i_tick = 1'b0;
    cyc();
    bus.i_tick = 1'b1;
    cyc();
    checks++;
    if (bus.o_tick_done !== 1'b1 || bus.o_move_start !== 1'b0) begin
      errors++;
      $display("FAIL go_ack2 done=%b start=%b exp=1,0",
               bus.o_tick_done, bus.o_move_start);
    end
    bus.i_tick = 1'b0;
    cyc();
    bus.i_up = 1'b1;
    cyc();
    bus.i_restart = 1'b1;
    cyc();
    cyc();
    checks++;
    if (bus.o_game_over !== 1'b1 || bus.o_clear_start !== 1'b0) begin
      errors++;
      $display("FAIL restart_gesture over=%b clr=%b exp=1,0",
               bus.o_game_over, bus.o_clear_start);
    end
    bus.i_restart = 1'b0;
    bus.i_up = 1'b0;
    cyc();
    bus.i_restart = 1'b1;
    cyc();
    bus.i_restart = 1'b0;
    checks++;
    if (bus.o_game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart_exit got=%b exp=0", bus.o_game_over);
    end
    run_clear("restart");
    run_tick();
    checks++;
    if (bus.o_dir !== 2'd0) begin
      errors++;
      $display("FAIL pending_cleared got=%0d exp=0", bus.o_dir);
    end
  endtask

  task automatic test_limit_done_wins();
    bus.i_tick = 1'b1;
    bus.i_vblank = 1'b1;
    cyc();
    repeat (254) cyc();
    bus.i_move_done = 1'b1;
    cyc();
    bus.i_move_done = 1'b0;
    checks++;
    if ({bus.o_tick_done, bus.o_game_over, bus.o_fault} !== 3'b100) begin
      errors++;
      $display("FAIL limit_done_wins got=%b exp=100",
               {bus.o_tick_done, bus.o_game_over, bus.o_fault});
    end
    bus.i_tick = 1'b0;
    cyc();
  endtask

  task automatic test_timeout_overrun();
    bus.i_tick = 1'b1;
    bus.i_vblank = 1'b1;
    cyc();
    bus.i_vblank = 1'b0;
    cyc();
    bus.i_vblank = 1'b1;
    checks++;
    if (bus.o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got=%b exp=1", bus.o_overrun);
    end
    bus.i_move_done = 1'b1;
    bus.i_ate = 1'b1;
    cyc();
    bus.i_move_done = 1'b0;
    bus.i_ate = 1'b0;
    bus.i_grow_done = 1'b1;
    cyc();
    bus.i_grow_done = 1'b0;
    checks++;
    if (bus.o_food_start !== 1'b1) begin
      errors++;
      $display("FAIL to_food_start got=%b exp=1", bus.o_food_start);
    end
    repeat (254) cyc();
    checks++;
    if (bus.o_game_over !== 1'b0 || bus.o_mem_grant !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early over=%b grant=%b exp=0,1",
               bus.o_game_over, bus.o_mem_grant);
    end
    cyc();
    checks++;
    if ({bus.o_game_over, bus.o_fault, bus.o_overrun} !== 3'b111) begin
      errors++;
      $display("FAIL timeout got=%b exp=111",
               {bus.o_game_over, bus.o_fault, bus.o_overrun});
    end
    bus.i_tick = 1'b0;
    cyc();
    bus.i_restart = 1'b1;
    cyc();
    bus.i_restart = 1'b0;
    cyc();
    checks++;
    if (bus.o_overrun !== 1'b1 || bus.o_fault !== 1'b1) begin
      errors++;
      $display("FAIL sticky_in_clear ovr=%b flt=%b exp=1,1",
               bus.o_overrun, bus.o_fault);
    end
    run_clear("fault");
    checks++;
    if (bus.o_overrun !== 1'b0 || bus.o_fault !== 1'b0) begin
      errors++;
      $display("FAIL sticky_cleared ovr=%b flt=%b exp=0,0",
               bus.o_overrun, bus.o_fault);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_tick = 1'b0;
    bus.i_vblank = 1'b0;
    bus.i_up = 1'b0;
    bus.i_down = 1'b0;
    bus.i_left = 1'b0;
    bus.i_right = 1'b0;
    bus.i_restart = 1'b0;
    bus.i_move_done = 1'b0;
    bus.i_collision = 1'b0;
    bus.i_ate = 1'b0;
    bus.i_grow_done = 1'b0;
    bus.i_food_done = 1'b0;
    bus.i_clear_done = 1'b0;
    test_reset();
    test_vblank_gate();
    test_grow();
    test_direction();
    test_collision_restart();
    test_limit_done_wins();
    test_timeout_overrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Per-tick controller for the snake game update datapath.
- Consumes the level-held game tick from the tick generator and gates the start on vertical blanking.
- Runs the move, grow and food phases through start/done handshakes with the sub-units, owning the shared snake memory grant throughout.
- Latches player direction with reversal rejection, handles game-over and restart-clear, and returns tick_done to release the tick.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles any single phase may wait for its done before abort.
- TO_W, 8: width of the phase timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- i_tick  in  1  game tick, level; held high until o_tick_done seen
- o_tick_done  out  1  tick acknowledge
- i_vblank  in  1  renderer in vertical blank (memory free)
- i_up, i_down, i_left, i_right  in  1 each  debounced direction buttons
- i_restart  in  1  restart button
- o_dir  out  2  committed direction: 0 right, 1 down, 2 left, 3 up
- o_move_start  out  1  one-cycle pulse, start head move/collision unit
- i_move_done  in  1  move complete; qualifies i_collision, i_ate
- i_collision  in  1  head hit wall/body
- i_ate  in  1  head landed on food
- o_grow_start, i_grow_done  out/in  1  grow-tail handshake
- o_food_start, i_food_done  out/in  1  food respawn handshake
- o_clear_start, i_clear_done  out/in  1  board clear handshake
- o_mem_grant  out  1  game logic owns snake memory
- o_game_over  out  1  game-over state
- o_overrun  out  1  sticky: vblank ended while memory granted
- o_fault  out  1  sticky: phase timeout occurred

Behaviour:
- Reset: state CLEAR_REQ, o_dir=0, pending dir=0, all outputs 0, timeout counter 0, restart edge register 0.
- States: CLEAR_REQ, CLEAR_WAIT, IDLE, MOVE_WAIT, GROW_WAIT, FOOD_WAIT, DONE, GAME_OVER.
- CLEAR_REQ: pulse o_clear_start for 1 cycle, then go to CLEAR_WAIT. CLEAR_WAIT: on i_clear_done, go to IDLE; o_dir=0, pending=0; o_fault and o_overrun cleared.
- IDLE: when i_tick=1 and i_vblank=1, commit pending to o_dir, pulse o_move_start in the same cycle, go to MOVE_WAIT. i_tick with i_vblank=0 waits in IDLE.
- MOVE_WAIT, on i_move_done:
  - i_collision=1 → GAME_OVER (ate ignored).
  - else i_ate=1 → pulse o_grow_start, go to GROW_WAIT.
  - else → DONE.
- GROW_WAIT: on i_grow_done, pulse o_food_start, go to FOOD_WAIT. FOOD_WAIT: on i_food_done, go to DONE.
- DONE: o_tick_done=1 while in DONE; return to IDLE when i_tick=0. No new sequence can start on the same tick.
- GAME_OVER: o_game_over=1. o_tick_done=i_tick, so ticks are acknowledged without game action and the tick generator never stalls.
- o_mem_grant=1 in CLEAR_WAIT, MOVE_WAIT, GROW_WAIT, FOOD_WAIT; 0 otherwise. Renderer must not read while it is high.
- o_overrun set on any cycle with o_mem_grant=1 and i_vblank=0; the sequence continues regardless.
- Timeout counter:
  - Resets to 0 on every start pulse and counts in each *_WAIT state.
  - Reaching TIMEOUT_CYCLES without done sets o_fault and goes to GAME_OVER.
  - In CLEAR_WAIT it sets o_fault and goes to IDLE.
  - A done arriving in the same cycle as the limit wins.
- Direction latch, evaluated every cycle in every state:
  - Priority up > down > left > right.
  - Candidate accepted into pending unless it is the opposite of o_dir (opposite = o_dir ^ 2).
  - Pending updates freely between ticks; last accepted value wins.
  - o_dir changes only at move start.
- Restart:
  - Acts on the rising edge of i_restart, and only when no direction button is held; restart plus a held direction is the speed/colourblind config gesture and is ignored here.
  - Accepted in GAME_OVER and IDLE → CLEAR_REQ.
  - Ignored in all other states; it is not queued.
- Start pulses are exactly one cycle; done inputs outside their wait state are ignored.
- Reset mid-sequence returns to CLEAR_REQ; sub-units are reset by the same rst_n.

Test Plan:
- Reset, i_clear_done after 3 cycles → o_clear_start pulse at cycle 1, o_mem_grant high 3 cycles, state IDLE, o_dir=0.
- i_tick=1, i_vblank=0 for 10 cycles, then vblank=1 → no o_move_start until vblank; then 1 pulse; move_done with ate=0 → o_tick_done high until i_tick drops, then exactly one sequence per tick.
- move_done with ate=1 → o_grow_start pulse; grow_done → o_food_start; food_done → DONE. Order of pulses checked, each 1 cycle.
- o_dir=0, press left → pending unchanged (reversal); press up then down across ticks → o_dir=3, then 1 rejected (stays 3); up+right held together → 3.
- move_done with i_collision=1 and i_ate=1 → GAME_OVER, no grow; subsequent ticks acked in 1 cycle. Restart with i_up held → ignored; bare restart → clear sequence, o_dir=0.
- Withhold i_food_done, TIMEOUT_CYCLES=255 → GAME_OVER at cycle 255 with o_fault=1. Drop i_vblank mid MOVE_WAIT → o_overrun=1 sticky until clear completes.
